// File: rtl/evm_ballot_ctrl_if.sv
// evm_ballot_ctrl_if: voter-panel and tally-datapath signals of the ballot controller.
interface evm_ballot_ctrl_if #(parameter int CNT_W = 32);
  logic             vote_valid;
  logic [1:0]       vote_sel;
  logic             ballot_en;
  logic             tally_req;
  logic [1:0]       tally_sel;
  logic             tally_ack;
  logic [1:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  modport master (
    input  vote_valid, vote_sel, tally_ack, rd_data,
    output ballot_en, tally_req, tally_sel, rd_sel
  );
  modport slave (
    output vote_valid, vote_sel, tally_ack, rd_data,
    input  ballot_en, tally_req, tally_sel, rd_sel
  );
endinterface

// File: rtl/evm_ballot_ctrl.sv
// evm_ballot_ctrl: arms one ballot per authorization, commits it to the tally, then scans for the winner.
module evm_ballot_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  authorize,
  input  logic                  close_poll,
  evm_ballot_ctrl_if.master     bus,
  output logic                  poll_open,
  output logic                  timeout_pulse,
  output logic [CNT_W-1:0]      total_votes,
  output logic [1:0]            winner,
  output logic                  tie,
  output logic                  result_valid
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ARMED, COMMIT, SCAN, RESULT} state_t;
  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       tally_sel_q, tally_sel_d, rd_sel_q, rd_sel_d, winner_q, winner_d;
  logic             tie_q, tie_d, timeout_pulse_q, timeout_pulse_d;
  logic [CNT_W-1:0] total_q, total_d, max_q, max_d;
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    tally_sel_d     = tally_sel_q;
    rd_sel_d        = rd_sel_q;
    winner_d        = winner_q;
    tie_d           = tie_q;
    max_d           = max_q;
    total_d         = total_q;
    timeout_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (close_poll) begin
          state_d  = SCAN;
          rd_sel_d = 2'd0;
        end else if (authorize) begin
          state_d = ARMED;
          timer_d = '0;
        end
      end
      ARMED: begin
        // a vote on the expiry edge takes priority over the timeout
        if (bus.vote_valid) begin
          state_d     = COMMIT;
          tally_sel_d = bus.vote_sel;
        end else if (timer_q == TMAX) begin
          state_d         = IDLE;
          timeout_pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      COMMIT: begin
        if (bus.tally_ack) begin
          state_d = IDLE;
          total_d = &total_q ? total_q : total_q + 1'b1;
        end
      end
      SCAN: begin
        if (rd_sel_q == 2'd0) begin
          max_d    = bus.rd_data;
          winner_d = 2'd0;
          tie_d    = 1'b0;
        end else if (bus.rd_data > max_q) begin
          max_d    = bus.rd_data;
          winner_d = rd_sel_q;
          tie_d    = 1'b0;
        end else if (bus.rd_data == max_q) begin
          tie_d = 1'b1;
        end
        state_d  = rd_sel_q == 2'd3 ? RESULT : SCAN;
        rd_sel_d = rd_sel_q == 2'd3 ? rd_sel_q : rd_sel_q + 2'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      tally_sel_q     <= 2'd0;
      rd_sel_q        <= 2'd0;
      winner_q        <= 2'd0;
      tie_q           <= 1'b0;
      max_q           <= '0;
      total_q         <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      tally_sel_q     <= tally_sel_d;
      rd_sel_q        <= rd_sel_d;
      winner_q        <= winner_d;
      tie_q           <= tie_d;
      max_q           <= max_d;
      total_q         <= total_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end
  assign bus.ballot_en  = state_q == ARMED;
  assign bus.tally_req  = state_q == COMMIT;
  assign bus.tally_sel  = tally_sel_q;
  assign bus.rd_sel     = rd_sel_q;
  assign poll_open      = !(state_q == SCAN || state_q == RESULT);
  assign timeout_pulse  = timeout_pulse_q;
  assign total_votes    = total_q;
  assign winner         = winner_q;
  assign tie            = tie_q;
  assign result_valid   = state_q == RESULT;
endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// tb_evm_ballot_ctrl: directed scenario tasks for the ballot controller with TIMEOUT=8.
module tb_evm_ballot_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic authorize = 1'b0;
  logic close_poll = 1'b0;
  logic poll_open, timeout_pulse, tie, result_valid;
  logic [31:0] total_votes;
  logic [1:0] winner;
  logic [31:0] tally_mem [4];
  int n_tests = 0;
  int n_fail = 0;
  int req_cnt = 0;
  bit be_seen = 1'b0;

  evm_ballot_ctrl_if #(.CNT_W(32)) bus ();

  evm_ballot_ctrl #(.CNT_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .authorize(authorize), .close_poll(close_poll),
    .bus(bus), .poll_open(poll_open), .timeout_pulse(timeout_pulse),
    .total_votes(total_votes), .winner(winner), .tie(tie), .result_valid(result_valid)
  );

  always #5 clk = ~clk;
  assign bus.rd_data = tally_mem[bus.rd_sel];
  always @(posedge bus.tally_req) req_cnt++;
  always @(posedge clk) if (bus.ballot_en) be_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; authorize = 1'b0; close_poll = 1'b0;
    bus.vote_valid = 1'b0; bus.vote_sel = 2'd0; bus.tally_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.ballot_en !== 1'b0) begin n_fail++; $display("FAIL reset_ballot_en got %0b exp 0", bus.ballot_en); end
    n_tests++; if (bus.tally_req !== 1'b0) begin n_fail++; $display("FAIL reset_tally_req got %0b exp 0", bus.tally_req); end
    n_tests++; if (poll_open !== 1'b1) begin n_fail++; $display("FAIL reset_poll_open got %0b exp 1", poll_open); end
    n_tests++; if (total_votes !== 32'd0) begin n_fail++; $display("FAIL reset_total got %0d exp 0", total_votes); end
    n_tests++; if ({result_valid, tie, winner, timeout_pulse, bus.rd_sel, bus.tally_sel} !== 9'd0) begin
      n_fail++; $display("FAIL reset_misc got %b exp 0", {result_valid, tie, winner, timeout_pulse, bus.rd_sel, bus.tally_sel}); end
  endtask

  task automatic test_vote();
    int r0 = req_cnt;
    authorize = 1'b1; tick(); authorize = 1'b0;
    n_tests++; if (bus.ballot_en !== 1'b1) begin n_fail++; $display("FAIL vote_armed got %0b exp 1", bus.ballot_en); end
    repeat (2) tick();
    bus.vote_valid = 1'b1; bus.vote_sel = 2'd2; tick(); bus.vote_valid = 1'b0; bus.vote_sel = 2'd0;
    n_tests++; if (bus.ballot_en !== 1'b0) begin n_fail++; $display("FAIL vote_disarm got %0b exp 0", bus.ballot_en); end
    n_tests++; if ({bus.tally_req, bus.tally_sel} !== 3'b110) begin n_fail++; $display("FAIL vote_req got %b exp 110", {bus.tally_req, bus.tally_sel}); end
    tick();
    n_tests++; if ({bus.tally_req, bus.tally_sel} !== 3'b110) begin n_fail++; $display("FAIL vote_req_hold got %b exp 110", {bus.tally_req, bus.tally_sel}); end
    bus.tally_ack = 1'b1; tick(); bus.tally_ack = 1'b0;
    n_tests++; if (bus.tally_req !== 1'b0) begin n_fail++; $display("FAIL vote_req_drop got %0b exp 0", bus.tally_req); end
    n_tests++; if (total_votes !== 32'd1) begin n_fail++; $display("FAIL vote_total got %0d exp 1", total_votes); end
    n_tests++; if (req_cnt - r0 !== 1) begin n_fail++; $display("FAIL vote_req_windows got %0d exp 1", req_cnt - r0); end
  endtask

  task automatic test_timeout();
    int r0 = req_cnt;
    authorize = 1'b1; tick(); authorize = 1'b0;
    repeat (7) tick();
    n_tests++; if ({bus.ballot_en, timeout_pulse} !== 2'b10) begin n_fail++; $display("FAIL to_before got %b exp 10", {bus.ballot_en, timeout_pulse}); end
    tick();
    n_tests++; if ({bus.ballot_en, timeout_pulse, bus.tally_req} !== 3'b010) begin n_fail++; $display("FAIL to_expire got %b exp 010", {bus.ballot_en, timeout_pulse, bus.tally_req}); end
    tick();
    n_tests++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL to_one_cycle got %0b exp 0", timeout_pulse); end
    n_tests++; if (total_votes !== 32'd1 || req_cnt != r0) begin n_fail++; $display("FAIL to_no_tally total %0d reqs %0d exp 1 0", total_votes, req_cnt - r0); end
    authorize = 1'b1; tick(); authorize = 1'b0;
    repeat (7) tick();
    bus.vote_valid = 1'b1; bus.vote_sel = 2'd0; tick(); bus.vote_valid = 1'b0;
    n_tests++; if ({bus.tally_req, timeout_pulse, bus.tally_sel} !== 4'b1000) begin n_fail++; $display("FAIL to_edge_vote got %b exp 1000", {bus.tally_req, timeout_pulse, bus.tally_sel}); end
    bus.tally_ack = 1'b1; tick(); bus.tally_ack = 1'b0;
    n_tests++; if (total_votes !== 32'd2) begin n_fail++; $display("FAIL to_edge_total got %0d exp 2", total_votes); end
  endtask

  task automatic test_double_vote();
    bus.vote_valid = 1'b1; bus.vote_sel = 2'd3; tick();
    n_tests++; if ({bus.tally_req, bus.ballot_en} !== 2'b00) begin n_fail++; $display("FAIL idle_vote got %b exp 00", {bus.tally_req, bus.ballot_en}); end
    bus.vote_valid = 1'b0;
    authorize = 1'b1; tick(); authorize = 1'b0;
    bus.vote_valid = 1'b1; bus.vote_sel = 2'd1; tick();
    bus.vote_sel = 2'd3; tick(); bus.vote_valid = 1'b0;
    n_tests++; if ({bus.tally_req, bus.tally_sel} !== 3'b101) begin n_fail++; $display("FAIL dbl_first got %b exp 101", {bus.tally_req, bus.tally_sel}); end
    bus.tally_ack = 1'b1; tick(); bus.tally_ack = 1'b0;
    n_tests++; if (total_votes !== 32'd3) begin n_fail++; $display("FAIL dbl_total got %0d exp 3", total_votes); end
  endtask

  task automatic test_close_armed();
    tally_mem = '{32'd5, 32'd9, 32'd9, 32'd2};
    authorize = 1'b1; tick(); authorize = 1'b0; close_poll = 1'b1;
    repeat (2) tick();
    n_tests++; if ({bus.ballot_en, poll_open} !== 2'b11) begin n_fail++; $display("FAIL close_armed got %b exp 11", {bus.ballot_en, poll_open}); end
    bus.vote_valid = 1'b1; bus.vote_sel = 2'd2; tick(); bus.vote_valid = 1'b0;
    n_tests++; if (bus.tally_req !== 1'b1) begin n_fail++; $display("FAIL close_commit got %0b exp 1", bus.tally_req); end
    bus.tally_ack = 1'b1; tick(); bus.tally_ack = 1'b0;
    n_tests++; if ({total_votes, poll_open} !== {32'd4, 1'b1}) begin n_fail++; $display("FAIL close_total got %0d/%0b exp 4/1", total_votes, poll_open); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if ({poll_open, result_valid, bus.rd_sel} !== {2'b00, 2'(i)}) begin n_fail++; $display("FAIL scan_step%0d got %b exp 00%b", i, {poll_open, result_valid, bus.rd_sel}, 2'(i)); end
    end
    tick();
    n_tests++; if ({result_valid, winner, tie} !== 4'b1011) begin n_fail++; $display("FAIL scan_tie got %b exp 1011", {result_valid, winner, tie}); end
    repeat (2) tick();
    n_tests++; if ({result_valid, winner, tie} !== 4'b1011) begin n_fail++; $display("FAIL result_hold got %b exp 1011", {result_valid, winner, tie}); end
    close_poll = 1'b0;
  endtask

  task automatic test_simul_close();
    do_reset();
    tally_mem = '{32'd7, 32'd3, 32'd7, 32'd8};
    be_seen = 1'b0;
    authorize = 1'b1; close_poll = 1'b1;
    repeat (5) tick();
    authorize = 1'b0; close_poll = 1'b0;
    n_tests++; if ({result_valid, winner, tie} !== 4'b1110) begin n_fail++; $display("FAIL simul_result got %b exp 1110", {result_valid, winner, tie}); end
    n_tests++; if (be_seen !== 1'b0 || total_votes !== 32'd0) begin n_fail++; $display("FAIL simul_no_ballot be %0b total %0d exp 0 0", be_seen, total_votes); end
  endtask

  task automatic test_reset_commit();
    do_reset();
    authorize = 1'b1; tick(); authorize = 1'b0;
    bus.vote_valid = 1'b1; bus.vote_sel = 2'd3; tick(); bus.vote_valid = 1'b0;
    tick();
    n_tests++; if (bus.tally_req !== 1'b1) begin n_fail++; $display("FAIL rc_req got %0b exp 1", bus.tally_req); end
    #2 reset = 1'b0; #1;
    n_tests++; if ({bus.tally_req, bus.ballot_en, bus.tally_sel, poll_open} !== 5'b00001) begin n_fail++; $display("FAIL rc_async got %b exp 00001", {bus.tally_req, bus.ballot_en, bus.tally_sel, poll_open}); end
    tick(); reset = 1'b1; tick();
    n_tests++; if ({bus.tally_req, total_votes} !== 33'd0) begin n_fail++; $display("FAIL rc_idle req %0b total %0d exp 0 0", bus.tally_req, total_votes); end
    authorize = 1'b1; tick(); authorize = 1'b0;
    n_tests++; if (bus.ballot_en !== 1'b1) begin n_fail++; $display("FAIL rc_rearm got %0b exp 1", bus.ballot_en); end
    bus.vote_valid = 1'b1; bus.vote_sel = 2'd1; tick(); bus.vote_valid = 1'b0;
    bus.tally_ack = 1'b1; tick(); bus.tally_ack = 1'b0;
    n_tests++; if ({bus.tally_req, bus.tally_sel, total_votes} !== {1'b0, 2'd1, 32'd1}) begin n_fail++; $display("FAIL rc_fresh sel %0d total %0d exp 1 1", bus.tally_sel, total_votes); end
  endtask

  initial begin
    tally_mem = '{32'd0, 32'd0, 32'd0, 32'd0};
    test_reset();
    test_vote();
    test_timeout();
    test_double_vote();
    test_close_armed();
    test_simul_close();
    test_reset_commit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
